// File: rtl/fpga_cfg_pkg.sv
// Shared types for the scan-chain configuration controller and the
// chain lengths of the fabric generations that use it.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        DONE     = 3'd4
    } cfg_state_t;

    typedef enum logic {
        CFG_LOAD   = 1'b0,
        CFG_VERIFY = 1'b1
    } cfg_mode_t;

    localparam int FPGAV1_CHAIN_LEN = 26;
    localparam int FPGAV2_CHAIN_LEN = 74;

endpackage

// File: rtl/fpga_cfg_serializer.sv
// Holds one bitstream word and presents it LSB-first, one bit per shift,
// with a count of bits consumed so the controller knows when to refetch.
module fpga_cfg_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data,
    output logic              cur_bit,
    output logic              next_bit,
    output logic              last
);

    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_shr;
    logic [BW-1:0]     cnt;

    assign word_shr = word_q >> 1;

    always_ff @(posedge clk) begin
        if (load) begin
            word_q <= data;
        end else if (shift) begin
            word_shr_hold: word_q <= word_shr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (shift) begin
            cnt <= cnt + 1'b1;
        end
    end

    // next_bit is the bit that will sit at position 0 after this edge
    assign cur_bit  = word_q[0];
    assign next_bit = load ? data[0] : (shift ? word_shr[0] : word_q[0]);
    assign last     = (cnt == BW'(WORD_W - 1));

endmodule

// File: rtl/fpga_cfg_loader.sv
// Scan-chain configuration controller: streams words into the chain in LOAD
// mode, or rotates the chain through itself and compares it in VERIFY mode.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 26,
    parameter int WORD_W    = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             mode,
    input  logic                             abort,
    input  logic                             s_valid,
    input  logic [WORD_W-1:0]                s_data,
    output logic                             s_ready,
    output logic                             prog_clk,
    output logic                             prog_en,
    output logic                             prog_in,
    input  logic                             prog_out,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   err_idx
);

    localparam int KW = $clog2(CHAIN_LEN + 1);
    localparam logic [KW-1:0] LAST_K    = KW'(CHAIN_LEN - 1);
    localparam logic [KW-1:0] ABORT_IDX = KW'(CHAIN_LEN);

    cfg_state_t    state, state_n;
    cfg_mode_t     mode_q;
    logic [KW-1:0] k;
    logic          busy_now, load, shift, mismatch;
    logic          cur_bit, next_bit, last_bit;

    assign busy_now = (state == FETCH) || (state == SHIFT_LO) || (state == SHIFT_HI);
    assign load     = (state == FETCH) && s_valid && !abort;
    assign shift    = (state == SHIFT_HI) && !abort;
    assign mismatch = (state == SHIFT_LO) && (mode_q == CFG_VERIFY) && (prog_out != cur_bit);

    fpga_cfg_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .data     (s_data),
        .cur_bit  (cur_bit),
        .next_bit (next_bit),
        .last     (last_bit)
    );

    always_comb begin
        state_n = state;
        if (busy_now && abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:     if (start) state_n = FETCH;
                FETCH:    if (s_valid) state_n = SHIFT_LO;
                SHIFT_LO: state_n = SHIFT_HI;
                SHIFT_HI: begin
                    // the last word may be partial: k, not the word count, ends the pass
                    if (k == LAST_K)   state_n = DONE;
                    else if (last_bit) state_n = FETCH;
                    else               state_n = SHIFT_LO;
                end
                DONE:     state_n = IDLE;
                default:  state_n = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= CFG_LOAD;
            k        <= '0;
            s_ready  <= 1'b0;
            prog_clk <= 1'b0;
            prog_en  <= 1'b0;
            prog_in  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_idx  <= '0;
        end else begin
            state    <= state_n;
            s_ready  <= (state_n == FETCH);
            prog_en  <= (state_n == FETCH) || (state_n == SHIFT_LO) || (state_n == SHIFT_HI);
            busy     <= (state_n == FETCH) || (state_n == SHIFT_LO) || (state_n == SHIFT_HI);
            prog_clk <= (state_n == SHIFT_HI);
            done     <= (state_n == DONE);
            // VERIFY feeds the tail back in so a full pass is a pure rotation
            if (state_n == SHIFT_LO) begin
                prog_in <= (mode_q == CFG_VERIFY) ? prog_out : next_bit;
            end
            if ((state == IDLE) && start) begin
                mode_q  <= cfg_mode_t'(mode);
                k       <= '0;
                error   <= 1'b0;
                err_idx <= '0;
            end else if (busy_now && abort) begin
                error   <= 1'b1;
                err_idx <= ABORT_IDX;
            end else begin
                if (shift) begin
                    k <= k + 1'b1;
                end
                if (mismatch && !error) begin
                    error   <= 1'b1;
                    err_idx <= k;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader with a 10-bit chain and 4-bit words; a
// shift-register model stands in for the fabric chain.
module tb_fpga_cfg_loader;

    localparam int CL = 10;
    localparam int WW = 4;
    localparam int NW = 3;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, abort = 1'b0;
    logic       s_valid = 1'b0;
    logic [3:0] s_data = 4'h0;
    logic       s_ready, prog_clk, prog_en, prog_in, prog_out, busy, done, error;
    logic [3:0] err_idx;

    fpga_cfg_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .prog_clk(prog_clk), .prog_en(prog_en), .prog_in(prog_in), .prog_out(prog_out),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: shifts on prog_clk rise, tail is the oldest bit
    logic [CL-1:0] chain_m = '0;
    int rises = 0;
    always @(posedge prog_clk) begin
        chain_m <= {chain_m[CL-2:0], prog_in};
        rises   <= rises + 1;
    end
    assign prog_out = chain_m[CL-1];

    typedef struct packed {
        logic rdy, en, pclk, pin, pcare, bsy, dn, err;
        logic [3:0] idx;
    } exp_t;

    exp_t q[$];
    int total = 0, bad = 0;
    int t0 = 0, done_at = -1, r0 = 0;
    logic [3:0] words[NW];
    int stall[NW];
    int widx = NW, stall_left = 0;
    logic rdy_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic rdy, en, pclk, pin, pcare, bsy, dn, err,
                                input logic [3:0] idx);
        return {rdy, en, pclk, pin, pcare, bsy, dn, err, idx};
    endfunction

    function automatic logic [CL-1:0] chain_stream();
        logic [CL-1:0] v;
        for (int i = 0; i < CL; i++) v[i] = chain_m[CL-1-i];
        return v;
    endfunction

    // Expected per-cycle outputs of a full pass, from the protocol rules
    task automatic build(input logic md);
        logic err, sb, pin;
        logic [3:0] idx;
        logic [CL-1:0] stored;
        int k, nb;
        err = 1'b0; idx = 4'd0; k = 0;
        stored = chain_stream();
        q.delete();
        for (int wi = 0; wi < NW; wi++) begin
            nb = (CL - wi * WW < WW) ? CL - wi * WW : WW;
            for (int s = 0; s <= stall[wi]; s++) q.push_back(mk(1, 1, 0, 0, 0, 1, 0, err, idx));
            for (int b = 0; b < nb; b++) begin
                sb  = words[wi][b];
                pin = md ? stored[k] : sb;
                q.push_back(mk(0, 1, 0, pin, 1, 1, 0, err, idx));
                if (md && (stored[k] != sb) && !err) begin
                    err = 1'b1;
                    idx = k[3:0];
                end
                q.push_back(mk(0, 1, 1, pin, 1, 1, 0, err, idx));
                k++;
            end
        end
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, err, idx));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, err, idx));
    endtask

    // One cycle: compare against the model, then drive the word stream
    task automatic step();
        exp_t e;
        logic [10:0] got, want;
        @(negedge clk);
        if ((q.size() > 0) && (cyc - t0 >= 1)) begin
            e    = q.pop_front();
            got  = {s_ready, prog_en, prog_clk, prog_in & e.pcare, busy, done, error, err_idx};
            want = {e.rdy, e.en, e.pclk, e.pin & e.pcare, e.bsy, e.dn, e.err, e.idx};
            chk($sformatf("cycle%0d_outputs", cyc - t0), 32'(got), 32'(want));
        end
        if (done === 1'b1) done_at = cyc - t0;
        if (s_valid && rdy_prev && !abort) begin
            widx++;
            if (widx < NW) stall_left = stall[widx];
        end
        if ((widx < NW) && s_ready && (stall_left > 0)) begin
            s_valid = 1'b0;
            stall_left--;
        end else begin
            s_valid = (widx < NW);
            s_data  = (widx < NW) ? words[widx] : 4'h0;
        end
        rdy_prev = s_ready;
    endtask

    task automatic start_pass(input logic md, input logic [3:0] w0, w1, w2,
                              input int st2, input logic model);
        words[0] = w0; words[1] = w1; words[2] = w2;
        stall[0] = 0; stall[1] = 0; stall[2] = st2;
        widx = 0; stall_left = 0;
        s_valid = 1'b1; s_data = w0; rdy_prev = s_ready;
        start = 1'b1; mode = md;
        t0 = cyc; done_at = -1; r0 = rises;
        if (model) build(md); else q.delete();
        step();
        start = 1'b0; mode = 1'b0;
    endtask

    task automatic finish_pass(input string nm, input int exp_done);
        for (int i = 0; (i < 80) && (q.size() > 0); i++) step();
        chk({nm, "_drained"}, q.size(), 0);
        chk({nm, "_done_cycle"}, done_at, exp_done);
        chk({nm, "_rises"}, rises - r0, CL);
    endtask

    initial begin
        #12;
        chk("reset_outputs", {s_ready, prog_clk, prog_en, prog_in, busy, done, error, err_idx}, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_in_idle", {busy, error, err_idx}, 0);

        start_pass(1'b0, 4'hA, 4'h5, 4'h3, 0, 1'b1);
        finish_pass("load", 24);
        chk("load_chain", chain_stream(), 10'b1101011010);

        start_pass(1'b1, 4'hA, 4'h5, 4'h3, 0, 1'b1);
        finish_pass("verify_ok", 24);
        chk("verify_ok_err", {error, err_idx}, 0);
        chk("verify_ok_chain", chain_stream(), 10'b1101011010);

        start_pass(1'b1, 4'hA, 4'h7, 4'h3, 0, 1'b1);
        finish_pass("verify_bad", 24);
        chk("verify_bad_err", {error, err_idx}, {1'b1, 4'd5});
        chk("verify_bad_chain", chain_stream(), 10'b1101011010);

        start_pass(1'b0, 4'hA, 4'h5, 4'h3, 7, 1'b1);
        finish_pass("stall", 31);
        chk("stall_chain", chain_stream(), 10'b1101011010);

        start_pass(1'b0, 4'hA, 4'h5, 4'h3, 0, 1'b0);
        for (int i = 0; (i < 40) && (cyc - t0 < 15); i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        widx = NW;
        chk("abort_outputs", {s_ready, busy, prog_en, prog_clk, done, error, err_idx},
            {5'b00000, 1'b1, 4'd10});
        repeat (30) step();
        chk("abort_no_done", done_at, -1);
        chk("abort_rises", rises - r0, 6);
        chk("abort_sticky", {busy, error, err_idx}, {1'b0, 1'b1, 4'd10});

        start_pass(1'b0, 4'hA, 4'h5, 4'h3, 0, 1'b1);
        finish_pass("reload", 24);
        chk("reload_chain", chain_stream(), 10'b1101011010);

        start_pass(1'b0, 4'hA, 4'h5, 4'h3, 0, 1'b1);
        for (int i = 0; (i < 80) && (q.size() > 0); i++) begin
            start = (cyc - t0 == 4);
            mode  = start;
            step();
        end
        start = 1'b0; mode = 1'b0;
        chk("busy_start_done_cycle", done_at, 24);
        chk("busy_start_rises", rises - r0, CL);
        chk("busy_start_chain", chain_stream(), 10'b1101011010);

        start_pass(1'b0, 4'h3, 4'hC, 4'h1, 0, 1'b0);
        for (int i = 0; (i < 40) && (prog_clk !== 1'b1); i++) step();
        chk("reached_shift_hi", prog_clk, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs",
            {s_ready, prog_clk, prog_en, prog_in, busy, done, error, err_idx}, 0);
        widx = NW;
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("after_reset_idle", {s_ready, prog_en, busy, done, error}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
